// File: rtl/uart_receiver_if.sv
// Receive-side result bus of uart_receiver: captured byte, status pulses and busy flag.
interface uart_receiver_if;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    modport master (
        output data,
        output data_valid,
        output frame_error,
        output parity_error,
        output busy
    );

    modport slave (
        input data,
        input data_valid,
        input frame_error,
        input parity_error,
        input busy
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// The line is synchronized first and then sampled at the middle of each bit.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            serial_input_rx,
    uart_receiver_if.master rx_if
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_CNT = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_CNT = CLKS_PER_BIT - 1;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, rx_s_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                data_valid_q, data_valid_d;
    logic                frame_error_q, frame_error_d;
    logic                parity_error_q, parity_error_d;
    logic                busy_q, busy_d;
    logic                parity_bad;
    logic                cnt_half, cnt_full;

    assign cnt_half   = (cnt_q == CNT_W'(HALF_CNT));
    assign cnt_full   = (cnt_q == CNT_W'(FULL_CNT));
    // Even parity: the data bits plus the parity bit must XOR to zero.
    assign parity_bad = PARITY_EN && ((^shift_q) ^ parity_q);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        parity_d       = parity_q;
        data_d         = data_q;
        data_valid_d   = 1'b0;
        frame_error_d  = 1'b0;
        parity_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_half) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        bit_idx_d = '0;
                        state_d   = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                if (cnt_full) begin
                    cnt_d    = '0;
                    parity_d = rx_s_q;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a following start edge.
                if (cnt_full) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (parity_bad) begin
                            parity_error_d = 1'b1;
                        end else begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q        <= 1'b1;
            rx_s_q         <= 1'b1;
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            parity_q       <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            parity_error_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync1_q        <= serial_input_rx;
            rx_s_q         <= sync1_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            parity_q       <= parity_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            frame_error_q  <= frame_error_d;
            parity_error_q <= parity_error_d;
            busy_q         <= busy_d;
        end
    end

    assign rx_if.data         = data_q;
    assign rx_if.data_valid   = data_valid_q;
    assign rx_if.frame_error  = frame_error_q;
    assign rx_if.parity_error = parity_error_q;
    assign rx_if.busy         = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance and an even-parity instance share clock and reset.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;

    logic clk;
    logic rst_n;
    logic rx0;
    logic rx1;

    int checks;
    int errors;

    uart_receiver_if if0();
    uart_receiver_if if1();

    uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clk             (clk),
        .reset           (rst_n),
        .serial_input_rx (rx0),
        .rx_if           (if0)
    );

    uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clk             (clk),
        .reset           (rst_n),
        .serial_input_rx (rx1),
        .rx_if           (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping, sampled on the falling edge.
    int         dv0, fe0, pe0, busy_cyc0, run0, max_run0, adj0;
    int         dv1, fe1, pe1, adj1;
    logic       prev0, prev1;
    logic [7:0] cap0[$];
    logic [7:0] cap1[$];

    initial begin
        dv0 = 0; fe0 = 0; pe0 = 0; busy_cyc0 = 0; run0 = 0; max_run0 = 0; adj0 = 0;
        dv1 = 0; fe1 = 0; pe1 = 0; adj1 = 0;
        prev0 = 1'b0; prev1 = 1'b0;
    end

    always @(negedge clk) begin
        if (if0.data_valid) begin
            dv0++;
            cap0.push_back(if0.data);
            run0++;
            if (run0 > max_run0) max_run0 = run0;
        end else begin
            run0 = 0;
        end
        if (if0.frame_error) fe0++;
        if (if0.parity_error) pe0++;
        if (if0.busy) busy_cyc0++;
        if ((if0.data_valid | if0.frame_error | if0.parity_error) && prev0) adj0++;
        if (int'(if0.data_valid) + int'(if0.frame_error) + int'(if0.parity_error) > 1) adj0++;
        prev0 = if0.data_valid | if0.frame_error | if0.parity_error;
    end

    always @(negedge clk) begin
        if (if1.data_valid) begin
            dv1++;
            cap1.push_back(if1.data);
        end
        if (if1.frame_error) fe1++;
        if (if1.parity_error) pe1++;
        if ((if1.data_valid | if1.frame_error | if1.parity_error) && prev1) adj1++;
        if (int'(if1.data_valid) + int'(if1.frame_error) + int'(if1.parity_error) > 1) adj1++;
        prev1 = if1.data_valid | if1.frame_error | if1.parity_error;
    end

    task automatic drive_bit(input bit sel, input bit v, input int unsigned cycles);
        if (sel) rx1 = v;
        else     rx0 = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input bit use_par,
                              input bit par, input bit stop);
        drive_bit(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i], CPB);
        if (use_par) drive_bit(sel, par, CPB);
        drive_bit(sel, stop, CPB);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (if0.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", if0.data); end
        checks++; if (if0.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", if0.data_valid); end
        checks++; if (if0.frame_error !== 1'b0 || if0.parity_error !== 1'b0) begin errors++; $display("FAIL reset_err: got fe=%b pe=%b expected 0 0", if0.frame_error, if0.parity_error); end
        checks++; if (if0.busy !== 1'b0 || if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b expected 0/0", if0.busy, if1.busy); end
        checks++; if (if1.data !== 8'h00) begin errors++; $display("FAIL reset_data1: got %h expected 00", if1.data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (if0.busy !== 1'b0 || dv0 != 0) begin errors++; $display("FAIL reset_release: got busy=%b dv=%0d expected 0 0", if0.busy, dv0); end
    endtask

    task automatic test_8n1_a5();
        int dv_b, fe_b, pe_b, busy_b;
        dv_b = dv0; fe_b = fe0; pe_b = pe0; busy_b = busy_cyc0;
        max_run0 = 0;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, 8);
        checks++; if (if0.data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", if0.data); end
        checks++; if (dv0 - dv_b != 1) begin errors++; $display("FAIL a5_dv_count: got %0d expected 1", dv0 - dv_b); end
        checks++; if (max_run0 != 1) begin errors++; $display("FAIL a5_dv_width: got %0d expected 1", max_run0); end
        checks++; if (fe0 != fe_b || pe0 != pe_b) begin errors++; $display("FAIL a5_no_err: got fe=%0d pe=%0d expected 0 0", fe0 - fe_b, pe0 - pe_b); end
        checks++; if (!((busy_cyc0 - busy_b) >= 150 && (busy_cyc0 - busy_b) <= 154)) begin errors++; $display("FAIL a5_busy_len: got %0d expected 150..154", busy_cyc0 - busy_b); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end: got %b expected 0", if0.busy); end
    endtask

    task automatic test_glitch();
        int dv_b, fe_b, pe_b;
        dv_b = dv0; fe_b = fe0; pe_b = pe0;
        drive_bit(1'b0, 1'b0, 4);
        drive_bit(1'b0, 1'b1, 24);
        checks++; if (dv0 != dv_b || fe0 != fe_b || pe0 != pe_b) begin errors++; $display("FAIL glitch_pulses: got dv=%0d fe=%0d pe=%0d expected 0 0 0", dv0 - dv_b, fe0 - fe_b, pe0 - pe_b); end
        checks++; if (if0.data !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected a5", if0.data); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b expected 0", if0.busy); end
    endtask

    task automatic test_frame_error();
        int dv_b, fe_b;
        dv_b = dv0; fe_b = fe0;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 20);
        checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", if0.busy); end
        drive_bit(1'b0, 1'b0, 20);
        drive_bit(1'b0, 1'b1, 32);
        checks++; if (fe0 - fe_b != 1) begin errors++; $display("FAIL break_fe_count: got %0d expected 1", fe0 - fe_b); end
        checks++; if (dv0 != dv_b) begin errors++; $display("FAIL break_no_dv: got %0d expected 0", dv0 - dv_b); end
        checks++; if (if0.data !== 8'hA5) begin errors++; $display("FAIL break_data_kept: got %h expected a5", if0.data); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL break_idle: got busy %b expected 0", if0.busy); end
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, 8);
        checks++; if (if0.data !== 8'h81 || dv0 - dv_b != 1) begin errors++; $display("FAIL after_break_81: got data %h dv %0d expected 81 1", if0.data, dv0 - dv_b); end
    endtask

    task automatic test_back_to_back();
        int n_b;
        n_b = cap0.size();
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, 8);
        checks++; if (cap0.size() - n_b != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", cap0.size() - n_b); end
        if (cap0.size() - n_b == 2) begin
            checks++; if (cap0[n_b] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", cap0[n_b]); end
            checks++; if (cap0[n_b+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", cap0[n_b+1]); end
        end
    endtask

    task automatic test_parity();
        int dv_b, pe_b, fe_b;
        dv_b = dv1; pe_b = pe1; fe_b = fe1;
        // 0x07 has three ones, so the even parity bit must be 1.
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 1'b1, 8);
        checks++; if (pe1 - pe_b != 1) begin errors++; $display("FAIL par_bad_pe: got %0d expected 1", pe1 - pe_b); end
        checks++; if (dv1 != dv_b || fe1 != fe_b) begin errors++; $display("FAIL par_bad_other: got dv=%0d fe=%0d expected 0 0", dv1 - dv_b, fe1 - fe_b); end
        checks++; if (if1.data !== 8'h00) begin errors++; $display("FAIL par_bad_data: got %h expected 00", if1.data); end
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b1, 8);
        checks++; if (dv1 - dv_b != 1 || pe1 - pe_b != 1) begin errors++; $display("FAIL par_good_pulses: got dv=%0d pe=%0d expected 1 1", dv1 - dv_b, pe1 - pe_b); end
        checks++; if (if1.data !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h expected 07", if1.data); end
        checks++; if (pe0 != 0) begin errors++; $display("FAIL nopar_pe_tied: got %0d expected 0", pe0); end
    endtask

    task automatic test_reset_mid_frame();
        int dv_b;
        logic [7:0] b;
        b = 8'h5A;
        dv_b = dv0;
        drive_bit(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, b[i], CPB);
        drive_bit(1'b0, b[4], 8);
        checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", if0.busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if0.busy !== 1'b0 || if0.data !== 8'h00) begin errors++; $display("FAIL midreset_async: got busy=%b data=%h expected 0 00", if0.busy, if0.data); end
        @(negedge clk);
        rx0 = 1'b1;
        rst_n = 1'b1;
        drive_bit(1'b0, 1'b1, 2 * CPB);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, 8);
        checks++; if (dv0 - dv_b != 1) begin errors++; $display("FAIL midreset_dv_count: got %0d expected 1", dv0 - dv_b); end
        checks++; if (if0.data !== 8'h12) begin errors++; $display("FAIL midreset_data: got %h expected 12", if0.data); end
        checks++; if (adj0 != 0 || adj1 != 0) begin errors++; $display("FAIL pulse_exclusive: got %0d/%0d expected 0/0", adj0, adj1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rx0    = 1'b1;
        rx1    = 1'b1;
        test_reset();
        test_8n1_a5();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
